svm_ovo_serial_ctrl: RTL

Sequential controller that evaluates a 3-class one-vs-one SVM with a single shared 4b x 8b multiply-accumulate unit instead of 12 parallel multipliers. It walks 3 pairwise classifiers x 4 features over 12 MAC cycles, then runs the decision-matrix vote and the argmax. The result is returned on a valid/ready port. It sits between the feature front-end and the class consumer as the area-reduced, time-multiplexed variant of the combinational SVM top.

---
 rtl/svm_ovo_serial_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/svm_ovo_serial_ctrl.sv
// Time-multiplexed 3-class one-vs-one SVM: one 4b x 8b MAC walks 3 classifiers x 4 features,
// then votes and takes the argmax. Define SVM_PERF_CNT_EN to add the perf_cnt handshake counter.
module svm_ovo_serial_ctrl #(
    parameter int FEAT_W = 4,
    parameter int N_FEAT = 4,
    parameter int ACC_W  = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FEAT_W*N_FEAT-1:0] inp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out,
    output logic [5:0]               predo,
    output logic                     busy
`ifdef SVM_PERF_CNT_EN
    ,
    output logic [15:0]              perf_cnt
`endif
);

    localparam int PW = FEAT_W + 8;
    localparam logic signed [ACC_W-1:0] BIAS_0   = '0;
    localparam logic signed [ACC_W-1:0] BIAS_1_2 = -13'sd256;

    typedef enum logic [1:0] {IDLE, MAC, VOTE, HOLD} state_t;

    state_t                     state_q, state_d;
    logic [FEAT_W*N_FEAT-1:0]   feat_q, feat_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [1:0]                 c_q, c_d;
    logic [1:0]                 f_q, f_d;
    logic [2:0]                 n_q, n_d;
    logic [1:0]                 out_q, out_d;
    logic [5:0]                 predo_q, predo_d;
    logic                       out_valid_q, out_valid_d;

    logic [FEAT_W-1:0]          feat_sel;
    logic signed [7:0]          w_sel;
    logic signed [PW-1:0]       feat_ext, w_ext, prod;
    logic signed [ACC_W-1:0]    sum;
    logic [1:0]                 dm0, dm1, dm2, win_idx, win_val;

    // Row c of the weight matrix; features 0,1 share one weight and features 2,3 the other.
    function automatic logic signed [7:0] coef(input logic [1:0] c, input logic [1:0] f);
        case (c)
            2'd0:    coef = f[1] ? 8'shC0 : 8'sh40;
            2'd1:    coef = f[1] ? 8'sh80 : 8'sh7F;
            default: coef = f[1] ? 8'sh7F : 8'sh80;
        endcase
    endfunction

    always_comb begin
        feat_sel = feat_q[f_q*FEAT_W +: FEAT_W];
        w_sel    = coef(c_q, f_q);
        feat_ext = {{8{1'b0}}, feat_sel};
        w_ext    = {{FEAT_W{w_sel[7]}}, w_sel};
        prod     = feat_ext * w_ext;
        sum      = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};

        dm0 = {1'b0, ~n_q[0]} + {1'b0, ~n_q[1]};
        dm1 = {1'b0,  n_q[0]} + {1'b0, ~n_q[2]};
        dm2 = {1'b0,  n_q[1]} + {1'b0,  n_q[2]};
        if (dm0 >= dm1) begin
            win_idx = 2'd0;
            win_val = dm0;
        end else begin
            win_idx = 2'd1;
            win_val = dm1;
        end
    end

    always_comb begin
        state_d     = state_q;
        feat_d      = feat_q;
        acc_d       = acc_q;
        c_d         = c_q;
        f_d         = f_q;
        n_d         = n_q;
        out_d       = out_q;
        predo_d     = predo_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    feat_d  = inp;
                    c_d     = 2'd0;
                    f_d     = 2'd0;
                    acc_d   = BIAS_0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = sum;
                f_d   = f_q + 2'd1;
                if (f_q == 2'd3) begin
                    n_d[c_q] = sum[ACC_W-1];
                    if (c_q == 2'd2) begin
                        acc_d   = BIAS_0;
                        c_d     = 2'd0;
                        state_d = VOTE;
                    end else begin
                        acc_d = BIAS_1_2;
                        c_d   = c_q + 2'd1;
                    end
                end
            end
            VOTE: begin
                out_d       = (win_val >= dm2) ? win_idx : 2'd2;
                predo_d     = {dm0, dm1, dm2};
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            feat_q      <= '0;
            acc_q       <= '0;
            c_q         <= '0;
            f_q         <= '0;
            n_q         <= '0;
            out_q       <= '0;
            predo_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            feat_q      <= feat_d;
            acc_q       <= acc_d;
            c_q         <= c_d;
            f_q         <= f_d;
            n_q         <= n_d;
            out_q       <= out_d;
            predo_q     <= predo_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign predo     = predo_q;

`ifdef SVM_PERF_CNT_EN
    logic [15:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (out_valid_q && out_ready && (perf_cnt_q != 16'hFFFF))
            perf_cnt_d = perf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_cnt_q <= '0;
        else        perf_cnt_q <= perf_cnt_d;
    end

    assign perf_cnt = perf_cnt_q;
`endif

endmodule
